// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: ID/STATUS/CONTROL/PULSE plus NREG-4 user registers; write commits one edge after AW and W are both buffered, reads return one cycle after AR.
// Backpressure: AW/W stall while their buffer is full or a B is pending; AR stalls while an R is pending.
module axi_lite_slave_regs #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          NREG       = 16,
  parameter logic [31:0] ID_VALUE   = 32'h5174_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic [31:0]            s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  input  logic [31:0]            status_in,
  output logic [31:0]            ctrl_out,
  output logic [31:0]            pulse_out,
  output logic [(NREG-4)*32-1:0] user_regs
);

  localparam int IW = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  strb;
  } wbuf_t;

  logic                    rst_done;
  logic                    aw_full;
  logic [IW-1:0]           aw_idx;
  logic                    w_full;
  wbuf_t                   w_buf;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q;
  logic [31:0]             ctrl_q;
  logic [31:0]             pulse_q;
  logic [NREG-1:4][31:0]   user_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    commit;
  logic [31:0]             aw_sel;
  logic [31:0]             ar_sel;
  logic [1:0]              wr_resp;
  logic [1:0]              rd_resp;
  logic [31:0]             rd_val;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[31:ADDR_WIDTH], s_axi_awaddr[1:0],
                       s_axi_araddr[31:ADDR_WIDTH], s_axi_araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] dat,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[k*8 +: 8] = dat[k*8 +: 8];
    end
    return res;
  endfunction

  // Readies stay low until the first edge after reset release.
  assign s_axi_awready = rst_done && !aw_full && !bvalid_q;
  assign s_axi_wready  = rst_done && !w_full && !bvalid_q;
  assign s_axi_arready = rst_done && !rvalid_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_full && w_full;

  assign aw_sel = 32'(aw_idx);
  assign ar_sel = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    wr_resp = RESP_OKAY;
    if (aw_sel >= NREG) begin
      wr_resp = RESP_DECERR;
    end else if (aw_sel < 32'd2) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    rd_resp = RESP_OKAY;
    rd_val  = '0;
    if (ar_sel >= NREG) begin
      rd_resp = RESP_DECERR;
    end else begin
      case (ar_sel)
        32'd0:   rd_val = ID_VALUE;
        32'd1:   rd_val = status_in;
        32'd2:   rd_val = ctrl_q;
        32'd3:   rd_val = '0;
        default: begin
          for (int i = 4; i < NREG; i++) begin
            if (ar_sel == i) rd_val = user_q[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // AW/W holding buffers and the write response channel.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_buf    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_buf    <= '{dat: s_axi_wdata, strb: s_axi_wstrb};
      end
      if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register file; SLVERR/DECERR commits leave it untouched.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ctrl_q  <= CTRL_RESET;
      pulse_q <= '0;
      user_q  <= '0;
    end else begin
      pulse_q <= '0;
      if (commit && wr_resp == RESP_OKAY) begin
        if (aw_sel == 32'd2) ctrl_q  <= merge(ctrl_q, w_buf.dat, w_buf.strb);
        if (aw_sel == 32'd3) pulse_q <= merge('0, w_buf.dat, w_buf.strb);
        for (int i = 4; i < NREG; i++) begin
          if (aw_sel == i) user_q[i] <= merge(user_q[i], w_buf.dat, w_buf.strb);
        end
      end
    end
  end

  // Read data is captured from pre-commit state, so a same-edge write is not visible.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign ctrl_out     = ctrl_q;
  assign pulse_out    = pulse_q;
  assign user_regs    = user_q;

endmodule
